// File: rtl/uart_rx.sv
// Purpose : 8N1 UART receiver with a runtime-programmable bit period.
// Latency : byte strobe 2 cycles (synchronizer) after the mid-point sample of data bit 7.
// Backpressure: none; the strobe is a single-cycle pulse and must be taken when seen.
// Ports   : _i_protocols_uart_clk    - core clock, all state on rising edge
//           _i_protocols_uart_rst    - synchronous active-high reset
//           _i_protocols_uart_rx     - asynchronous serial line, idle high
//           _i_protocols_uart_config - bit period in clock cycles (values below 2 act as 2)
//           __output                 - {validn (active-low strobe), data[7:0]}
module uart_rx (
    input  logic        _i_protocols_uart_clk,
    input  logic        _i_protocols_uart_rst,
    input  logic        _i_protocols_uart_rx,
    input  logic [31:0] _i_protocols_uart_config,
    output logic [8:0]  __output
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [1:0]  fill;       // counts synchronizer fill after reset
    logic        armed;      // last trusted rx_s sample was high
    logic [31:0] period;     // bit period latched at the start bit
    logic [31:0] cnt;
    logic [2:0]  bit_index;
    logic [7:0]  shift;
    logic [7:0]  data;
    logic        validn;

    logic        sync_ok;
    logic [31:0] half;

    // rx_s only reflects the real line once both synchronizer flops have
    // been reloaded after reset; before that it still shows the reset value.
    assign sync_ok  = (fill == 2'd2);
    assign half     = {1'b0, period[31:1]};
    assign __output = {validn, data};

    always_ff @(posedge _i_protocols_uart_clk) begin
        if (_i_protocols_uart_rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            fill      <= 2'd0;
            armed     <= 1'b0;
            period    <= 32'd2;
            cnt       <= 32'd0;
            bit_index <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            validn    <= 1'b1;
            state     <= IDLE;
        end else begin
            rx_meta <= _i_protocols_uart_rx;
            rx_s    <= rx_meta;
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            validn <= 1'b1;

            case (state)
                IDLE: begin
                    // A start bit needs a real high-to-low transition: a line
                    // already low when reset releases never arms the detector.
                    if (sync_ok) begin
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            armed  <= 1'b0;
                            period <= (_i_protocols_uart_config < 32'd2) ? 32'd2
                                                                         : _i_protocols_uart_config;
                            cnt    <= 32'd0;
                            state  <= START;
                        end
                    end
                end

                START: begin
                    if (cnt == half - 32'd1) begin
                        cnt <= 32'd0;
                        if (rx_s) begin
                            // Glitch shorter than half a bit: drop it silently.
                            armed <= 1'b1;
                            state <= IDLE;
                        end else begin
                            bit_index <= 3'd0;
                            state     <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                DATA: begin
                    if (cnt == period - 32'd1) begin
                        cnt              <= 32'd0;
                        shift[bit_index] <= rx_s;
                        if (bit_index == 3'd7) begin
                            // Strobe straight away; the stop bit is checked
                            // afterwards and never retracts this byte.
                            data   <= {rx_s, shift[6:0]};
                            validn <= 1'b0;
                            state  <= STOP;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                STOP: begin
                    if (cnt == period - 32'd1) begin
                        cnt <= 32'd0;
                        if (rx_s) begin
                            armed <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Purpose : self-checking bench for uart_rx with a strobe scoreboard.
// Latency : n/a (testbench).
// Backpressure: n/a; the monitor samples every cycle shortly after the falling edge.
module tb_uart_rx;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [31:0] cfg;
    logic [8:0]  dout;

    uart_rx dut (
        ._i_protocols_uart_clk    (clk),
        ._i_protocols_uart_rst    (rst),
        ._i_protocols_uart_rx     (rx),
        ._i_protocols_uart_config (cfg),
        .__output                 (dout)
    );

    typedef struct {
        logic [7:0] b;
        int         t7;   // cycle at which data bit 7 started on the line
        int         p;    // bit period used for that frame
    } exp_t;

    exp_t exp_q[$];
    int   strobe_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame. alt_cfg != 0 changes config during data bit 3
    // and restores it after the stop bit.
    task automatic send_frame(input logic [7:0] b, input int p, input logic stop_bit,
                              input int alt_cfg);
        exp_t e;
        e.b  = b;
        e.p  = p;
        e.t7 = -1;
        rx = 1'b0;
        wait_cyc(p);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == 3 && alt_cfg != 0) cfg = alt_cfg;
            if (i == 7) begin
                e.t7 = cyc;
                exp_q.push_back(e);
            end
            wait_cyc(p);
        end
        rx = stop_bit;
        wait_cyc(p);
        if (alt_cfg != 0) cfg = p;
    endtask

    // Monitor: pops the scoreboard on every strobe, checks pulse width,
    // strobe timing and that data never moves without a strobe.
    initial begin
        logic [7:0] prev_data;
        logic       prev_validn;
        exp_t       e;
        int         d;
        prev_data   = 8'h00;
        prev_validn = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (dout[8] === 1'b0) begin
                    check("strobe_width", {31'd0, prev_validn}, 32'd1);
                    strobe_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: actual data %02h, required no strobe (cycle %0d)",
                                 dout[7:0], cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_data", {24'd0, dout[7:0]}, {24'd0, e.b});
                        d = cyc - e.t7;
                        checks++;
                        if (!(d >= 1 && d <= e.p / 2 + 4 && d < e.p)) begin
                            errors++;
                            $display("FAIL strobe_timing: actual %0d cycles into bit 7, required 1..%0d",
                                     d, e.p / 2 + 4);
                        end
                    end
                end else if (!rst) begin
                    check("data_hold", {24'd0, dout[7:0]}, {24'd0, prev_data});
                end
                prev_data   = dout[7:0];
                prev_validn = dout[8];
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        rx  = 1'b1;
        cfg = 32'd100;
        wait_cyc(2);
        mon_en = 1'b1;
        wait_cyc(2);
        rst = 1'b0;

        // Reset state held for 100 idle cycles.
        for (int i = 0; i < 10; i++) begin
            wait_cyc(10);
            check("reset_validn", {31'd0, dout[8]}, 32'd1);
            check("reset_data", {24'd0, dout[7:0]}, 32'h00);
        end

        // Basic frame 0xCA.
        send_frame(8'hCA, 100, 1'b1, 0);
        wait_cyc(200);
        check("ca_data", {24'd0, dout[7:0]}, 32'hCA);
        check("ca_count", strobe_cyc.size(), 32'd1);

        // 30-cycle glitch, then 0x55 with config disturbed mid-frame.
        rx = 1'b0;
        wait_cyc(30);
        rx = 1'b1;
        wait_cyc(150);
        check("glitch_count", strobe_cyc.size(), 32'd1);
        check("glitch_data", {24'd0, dout[7:0]}, 32'hCA);
        send_frame(8'h55, 100, 1'b1, 7);
        wait_cyc(150);
        check("x55_data", {24'd0, dout[7:0]}, 32'h55);
        check("x55_count", strobe_cyc.size(), 32'd2);

        // Back-to-back frames at P=16.
        cfg = 32'd16;
        wait_cyc(50);
        send_frame(8'hA5, 16, 1'b1, 0);
        send_frame(8'h3C, 16, 1'b1, 0);
        wait_cyc(100);
        check("b2b_count", strobe_cyc.size(), 32'd4);
        if (strobe_cyc.size() >= 4)
            check("b2b_spacing", strobe_cyc[3] - strobe_cyc[2], 32'd160);
        check("b2b_data", {24'd0, dout[7:0]}, 32'h3C);

        // Framing error / break: 0xFF with stop bit low, line low 500 cycles.
        cfg = 32'd100;
        wait_cyc(100);
        send_frame(8'hFF, 100, 1'b0, 0);
        wait_cyc(400);
        check("break_count", strobe_cyc.size(), 32'd5);
        check("break_data", {24'd0, dout[7:0]}, 32'hFF);
        rx = 1'b1;
        wait_cyc(200);
        send_frame(8'h01, 100, 1'b1, 0);
        wait_cyc(200);
        check("after_break_data", {24'd0, dout[7:0]}, 32'h01);

        // Reset during data bit 4 with the line still low across release.
        n  = strobe_cyc.size();
        rx = 1'b0;
        wait_cyc(100);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_cyc(100);
        end
        rx = 1'b0;
        wait_cyc(50);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
        check("rst_validn", {31'd0, dout[8]}, 32'd1);
        check("rst_data", {24'd0, dout[7:0]}, 32'h00);
        wait_cyc(60);
        rx = 1'b1;
        wait_cyc(150);
        check("rst_no_strobe", strobe_cyc.size(), n);
        check("rst_data_held", {24'd0, dout[7:0]}, 32'h00);
        send_frame(8'h81, 100, 1'b1, 0);
        wait_cyc(200);
        check("x81_data", {24'd0, dout[7:0]}, 32'h81);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("total_strobes", strobe_cyc.size(), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have a single clock, _i_protocols_uart_clk (input, 1 bit); every register is updated on its rising edge.
REQ-002 SHALL have _i_protocols_uart_rst (input, 1 bit), a synchronous, active-high reset.
REQ-003 SHALL have _i_protocols_uart_rx (input, 1 bit): asynchronous serial line, idle high.
REQ-004 SHALL have _i_protocols_uart_config (input, 32 bits, unsigned): bit period in clock cycles.
REQ-005 SHALL have __output (output, 9 bits) = {validn, data[7:0]}:
- validn (bit 8): active-low byte-valid strobe.
- data (bits 7:0): received byte.

Function
REQ-006 SHALL pass rx through a 2-flop synchronizer; all decoding uses the synchronized value (rx_s).
REQ-007 SHALL decode the frame format 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-008 SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-009 IDLE: a 1-to-0 transition of rx_s SHALL latch the bit period P = max(config, 2), clear the cycle counter and enter START.
REQ-010 START: after floor(P/2) cycles (mid start bit), rx_s==0 SHALL enter DATA with counter and bit index cleared; rx_s==1 SHALL return to IDLE as a glitch, emitting nothing.
REQ-011 DATA: every P cycles (mid bit) SHALL sample rx_s into shift position bit_index (bit 0 first) and increment bit_index from 0 to 7.
REQ-012 On the sample of data bit 7, the next clock edge SHALL:
- load data with the 8 assembled bits;
- drive validn=0 for exactly one clock;
- enter STOP.
REQ-013 The validn pulse SHALL fall within the last data bit period, no later than 4 cycles after its midpoint.
- No stop-bit check precedes the strobe.
REQ-014 data SHALL hold its value until the next byte completes; it SHALL NOT change while validn=1.
REQ-015 STOP: after P cycles (mid stop bit), rx_s==1 SHALL enter IDLE; rx_s==0 SHALL enter BREAK.
- The byte already strobed is not retracted.
REQ-016 BREAK: SHALL wait for rx_s==1, then enter IDLE; it SHALL emit no strobe.
REQ-017 A falling edge in IDLE immediately after STOP SHALL be accepted as the start of the next frame; back-to-back frames are supported.
REQ-018 Changes to config mid-frame SHALL have no effect until the next start bit.
REQ-019 The cycle counter SHALL be 32 bits wide and SHALL NOT wrap within a bit period.

Reset
REQ-020 While rst=1 at a clock edge, the block SHALL enter IDLE with validn=1, data=0x00, counters=0, and synchronizer flops=1.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no strobe.
- Reception restarts only on a new falling edge after rst=0.
REQ-022 rx held low when reset deasserts SHALL NOT be treated as a start bit; a 1-to-0 transition is required.

Verification
REQ-023 After reset, rx=1 and config=100 -> validn=1, data=0x00 for 100 cycles.
REQ-024 config=100: idle 100 cycles, start bit, data bits 0,1,0,1,0,0,1,1 (100 cycles each), stop bit, 200 idle cycles ->
- exactly one validn=0 pulse, 1 cycle wide, with data=0xCA;
- the pulse occurs during the last data bit, before the stop bit begins;
- data stays 0xCA afterwards.
REQ-025 config=100, 30-cycle low glitch on idle rx -> no strobe; the block is back in IDLE and the next valid frame with byte 0x55 gives data=0x55.
REQ-026 config=16, two back-to-back frames 0xA5 then 0x3C with no idle gap -> two strobes, carrying 0xA5 then 0x3C, 160 cycles apart.
REQ-027 config=100, frame 0xFF with stop bit 0 and rx held low 500 cycles, then high, then frame 0x01 ->
- 0xFF is strobed;
- no further strobe while rx is low;
- 0x01 is received afterwards.
REQ-028 rst asserted during data bit 4 of a frame -> no strobe, validn=1, data=0x00; the next complete frame 0x81 gives data=0x81.
